// File: rtl/muldiv_seq.sv
// Sequential unsigned multiply/divide (shift-add, restoring) driving a shared external ALU.
// Optional build macro MULDIV_EARLY_OUT_EN: multiplies with a zero operand skip the iterations.
//
// state | meaning
// IDLE  | waiting for start; ALU driven with zeros/add
// CALC  | one multiply or divide bit per cycle, XLEN cycles
// DONE  | done pulse, result valid; returns to IDLE
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alu_ctr,
    input  logic [XLEN-1:0] alu_out,
    input  logic            alu_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       op_q, op_n;
    // acc = hi / rem, low = lo / quo, opnd = mcand / dvsr
    logic [XLEN-1:0]  acc, acc_n, low, low_n, opnd, opnd_n, result_n;
    logic [XLEN-1:0]  sh;
    logic             carry, take;
    logic             unused_alu_zero;

    assign unused_alu_zero = alu_zero;
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            op_q   <= '0;
            acc    <= '0;
            low    <= '0;
            opnd   <= '0;
            result <= '0;
        end else begin
            cnt    <= cnt_n;
            op_q   <= op_n;
            acc    <= acc_n;
            low    <= low_n;
            opnd   <= opnd_n;
            result <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        op_n     = op_q;
        acc_n    = acc;
        low_n    = low;
        opnd_n   = opnd;
        result_n = result;
        alu_a    = '0;
        alu_b    = '0;
        alu_ctr  = ALU_ADD;
        sh       = {acc[XLEN-2:0], low[XLEN-1]};
        carry    = (alu_out < acc);
        take     = acc[XLEN-1] || (sh >= opnd);

        unique case (state)
            IDLE: begin
                if (start) begin
                    op_n = op;
                    if (op[1] && (src_b == '0)) begin
                        state_n  = DONE;
                        result_n = op[0] ? src_a : '1;
`ifdef MULDIV_EARLY_OUT_EN
                    end else if (!op[1] && ((src_a == '0) || (src_b == '0))) begin
                        state_n  = DONE;
                        result_n = '0;
`endif
                    end else begin
                        state_n = CALC;
                        cnt_n   = '0;
                        acc_n   = '0;
                        low_n   = op[1] ? src_a : src_b;
                        opnd_n  = op[1] ? src_b : src_a;
                    end
                end
            end
            CALC: begin
                alu_b = opnd;
                if (op_q[1]) begin
                    alu_a   = sh;
                    alu_ctr = ALU_SUB;
                    acc_n   = take ? alu_out : sh;
                    low_n   = {low[XLEN-2:0], take};
                end else begin
                    alu_a = acc;
                    if (low[0]) begin
                        acc_n = {carry, alu_out[XLEN-1:1]};
                        low_n = {alu_out[0], low[XLEN-1:1]};
                    end else begin
                        acc_n = {1'b0, acc[XLEN-1:1]};
                        low_n = {acc[0], low[XLEN-1:1]};
                    end
                end
                cnt_n = cnt + CNT_W'(1);
                if (cnt == CNT_W'(XLEN - 1)) begin
                    state_n  = DONE;
                    cnt_n    = '0;
                    // MULHU/REMU take the upper register, MUL/DIVU the lower
                    result_n = op_q[0] ? acc_n : low_n;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: vector table, scoreboard queue and corner-case sequences.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = '0, src_b = '0;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [2:0]  alu_ctr;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    // external ALU model: add for 010, subtract for 110
    always_comb begin
        alu_out  = (alu_ctr == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);
        alu_zero = (alu_out == '0);
    end

    muldiv_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result(result), .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        logic        no_sub;
        string       name;
    } vec_t;

    vec_t vecs[10];

`ifdef MULDIV_EARLY_OUT_EN
    localparam int MUL0_LAT = 1;
`else
    localparam int MUL0_LAT = 33;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Drives one op, follows it to done, compares result, latency and busy profile.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input logic no_sub,
                          input string name);
        int cyc;
        logic busy_ok, saw_sub;
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        sb.push_back(exp);
        @(negedge clk);
        start = 1'b0; op = ~o; src_a = ~a; src_b = ~b;
        cyc = 1; busy_ok = 1'b1; saw_sub = 1'b0;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (alu_ctr != 3'b010) saw_sub = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
            void'(sb.pop_front());
            return;
        end
        if (!busy) busy_ok = 1'b0;
        if (alu_ctr != 3'b010) saw_sub = 1'b1;
        chk({name, " result"}, result, sb.pop_front());
        chk({name, " latency"}, 32'(cyc), 32'(lat));
        chk({name, " busy"}, {31'b0, busy_ok}, 32'd1);
        if (no_sub) chk({name, " alu_ctr"}, {31'b0, saw_sub}, 32'd0);
        @(negedge clk);
        chk({name, " idle"}, {30'b0, busy, done}, 32'd0);
        chk({name, " held"}, result, exp);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        int          cyc;

        vecs[0] = '{2'b00, 32'd7, 32'd6, 32'd42, 33, 1'b0, "mul_7x6"};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0, "mulhu_ff"};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33, 1'b0, "mul_ff"};
        vecs[3] = '{2'b10, 32'd100, 32'd7, 32'd14, 33, 1'b0, "divu_100_7"};
        vecs[4] = '{2'b11, 32'd100, 32'd7, 32'd2, 33, 1'b0, "remu_100_7"};
        vecs[5] = '{2'b10, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1, 33, 1'b0, "divu_top"};
        vecs[6] = '{2'b11, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 33, 1'b0, "remu_top"};
        vecs[7] = '{2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1, "divu_by0"};
        vecs[8] = '{2'b11, 32'd5, 32'd0, 32'd5, 1, 1'b1, "remu_by0"};
        vecs[9] = '{2'b00, 32'd0, 32'h1234, 32'd0, MUL0_LAT, 1'b0, "mul_zero"};

        #1;
        chk("rst busy/done", {30'b0, busy, done}, 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst alu", {alu_a[28:0], alu_ctr}, {29'b0, 3'b010});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                   vecs[i].no_sub, vecs[i].name);

        for (int i = 0; i < 6; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = $urandom();
            if (ro[1] && rb == 0) rb = 32'd3;
            if (!ro[1] && ra == 0) ra = 32'd9;
            if (!ro[1] && rb == 0) rb = 32'd11;
            run_op(ro, ra, rb, ref_model(ro, ra, rb), 33, 1'b0, "random");
        end

        // start pulses during CALC and during DONE must be ignored
        @(negedge clk);
        start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd6;
        sb.push_back(32'd42);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 60) begin
            if (cyc == 5) begin start = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd0; end
            else start = 1'b0;
            @(negedge clk);
            cyc++;
        end
        start = 1'b1; op = 2'b11; src_a = 32'd77; src_b = 32'd0;
        chk("ignore latency", 32'(cyc), 32'd33);
        chk("ignore result", result, sb.pop_front());
        @(negedge clk);
        start = 1'b0;
        chk("ignore idle", {30'b0, busy, done}, 32'd0);
        chk("ignore held", result, 32'd42);

        // reset at iteration 10 aborts the operation
        @(negedge clk);
        start = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort busy/done", {30'b0, busy, done}, 32'd0);
        chk("abort result", result, 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("abort no done", {31'b0, done}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(2'b10, 32'd100, 32'd7, 32'd14, 33, 1'b0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
